// File: rtl/gamma_mux_scheduler.sv
// rtl/gamma_mux_scheduler.sv - round-robin scheduler sharing one temporal mux among requesters
//
// Ports:
//   aclk, grst          clock; asynchronous active-high reset
//   req_valid/req_ready per-requester request and one-hot combinational grant (IDLE only)
//   req_select          packed selects, requester i at [i*SELECT_WIDTH +: SELECT_WIDTH]
//   mux_select          select held to the shared mux from the grant cycle onward
//   gamma_start         one-tick strobe at the first RUN tick
//   mux_out             per-lane match outputs from the mux, sampled only in RUN
//   rsp_valid/rsp_ready response handshake; rsp_id = serviced requester, rsp_data = sticky OR
//   busy                high while a service is in RUN or RESP
module gamma_mux_scheduler #(
   parameter int GAMMA_CYCLE_WIDTH = 16,
   parameter int NUM_INPUTS        = GAMMA_CYCLE_WIDTH,
   parameter int SELECT_WIDTH      = $clog2(GAMMA_CYCLE_WIDTH),
   parameter int NUM_REQ           = 4,
   parameter int MUX_LATENCY       = 2,
   parameter int ID_WIDTH          = $clog2(NUM_REQ)
) (
   input  logic                            aclk,
   input  logic                            grst,
   input  logic [NUM_REQ-1:0]              req_valid,
   input  logic [NUM_REQ*SELECT_WIDTH-1:0] req_select,
   output logic [NUM_REQ-1:0]              req_ready,
   output logic [SELECT_WIDTH-1:0]         mux_select,
   output logic                            gamma_start,
   input  logic [NUM_INPUTS-1:0]           mux_out,
   output logic                            rsp_valid,
   input  logic                            rsp_ready,
   output logic [ID_WIDTH-1:0]             rsp_id,
   output logic [NUM_INPUTS-1:0]           rsp_data,
   output logic                            busy
);

   localparam int RUN_TICKS  = GAMMA_CYCLE_WIDTH + MUX_LATENCY;
   localparam int TICK_WIDTH = $clog2(RUN_TICKS);
   localparam logic [TICK_WIDTH-1:0] LAST_TICK = TICK_WIDTH'(RUN_TICKS - 1);

   typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;

   state_t                  state;
   state_t                  state_next;
   logic [TICK_WIDTH-1:0]   tick;
   logic [NUM_INPUTS-1:0]   acc;
   logic [ID_WIDTH-1:0]     last_grant;
   logic [ID_WIDTH-1:0]     id_q;
   logic [ID_WIDTH-1:0]     grant_id;
   logic [ID_WIDTH-1:0]     cand;
   logic [NUM_REQ-1:0]      grant_vec;
   logic                    grant_any;

   // Round-robin search starting just after the last winner. The modulo keeps
   // the pointer legal for non-power-of-two requester counts.
   always_comb begin
      grant_any = 1'b0;
      grant_id  = '0;
      grant_vec = '0;
      cand      = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = ID_WIDTH'((int'(last_grant) + k) % NUM_REQ);
         if (!grant_any && req_valid[cand]) begin
            grant_any       = 1'b1;
            grant_id        = cand;
            grant_vec[cand] = 1'b1;
         end
      end
   end

   always_ff @(posedge aclk or posedge grst) begin
      if (grst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next  = state;
      req_ready   = '0;
      gamma_start = 1'b0;
      rsp_valid   = 1'b0;
      busy        = 1'b0;
      case (state)
         IDLE: begin
            // Grant is masked during reset so no requester sees a stray accept.
            if (!grst) begin
               req_ready = grant_vec;
            end
            if (grant_any) begin
               state_next = RUN;
            end
         end
         RUN: begin
            busy        = 1'b1;
            gamma_start = (tick == '0);
            if (tick == LAST_TICK) begin
               state_next = RESP;
            end
         end
         RESP: begin
            busy      = 1'b1;
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge aclk or posedge grst) begin
      if (grst) begin
         tick       <= '0;
         acc        <= '0;
         last_grant <= ID_WIDTH'(NUM_REQ - 1);
         mux_select <= '0;
         id_q       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_any) begin
                  mux_select <= req_select[grant_id*SELECT_WIDTH +: SELECT_WIDTH];
                  id_q       <= grant_id;
                  last_grant <= grant_id;
                  acc        <= '0;
                  tick       <= '0;
               end
            end
            RUN: begin
               // The last tick's mux_out is folded in on the same edge that leaves RUN.
               acc  <= acc | mux_out;
               tick <= tick + TICK_WIDTH'(1);
            end
            default: begin
            end
         endcase
      end
   end

   assign rsp_id   = id_q;
   assign rsp_data = acc;

endmodule

// File: tb/tb_gamma_mux_scheduler.sv
// tb/tb_gamma_mux_scheduler.sv - self-checking bench for gamma_mux_scheduler
module tb_gamma_mux_scheduler;

   localparam int NR = 4;
   localparam int SW = 4;
   localparam int NI = 16;
   localparam int IW = 2;
   localparam int RT = 18;   // ticks per service window (gamma cycle + mux latency)

   logic               aclk = 1'b0;
   logic               grst = 1'b0;
   logic [NR-1:0]      req_valid = '0;
   logic [NR*SW-1:0]   req_select = '0;
   logic [NR-1:0]      req_ready;
   logic [SW-1:0]      mux_select;
   logic               gamma_start;
   logic [NI-1:0]      mux_out = '0;
   logic               rsp_valid;
   logic               rsp_ready = 1'b0;
   logic [IW-1:0]      rsp_id;
   logic [NI-1:0]      rsp_data;
   logic               busy;

   int checks = 0;
   int errors = 0;

   always #5 aclk = ~aclk;

   gamma_mux_scheduler dut (
      .aclk        (aclk),
      .grst        (grst),
      .req_valid   (req_valid),
      .req_select  (req_select),
      .req_ready   (req_ready),
      .mux_select  (mux_select),
      .gamma_start (gamma_start),
      .mux_out     (mux_out),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_id      (rsp_id),
      .rsp_data    (rsp_data),
      .busy        (busy)
   );

   typedef struct {
      logic [3:0]  rv;
      int          ta;
      logic [15:0] pa;
      int          tb;
      logic [15:0] pb;
      logic [15:0] noise;
      logic [1:0]  exp_id;
      logic [15:0] exp_data;
   } vec_t;

   vec_t        vecs [6];
   logic [3:0]  sel_of [4];
   logic [15:0] sel_pack;

   // reference model state
   int          m_since;
   int          m_last;
   logic [3:0]  m_sel;
   logic [1:0]  m_id;
   logic [15:0] m_acc;
   logic [3:0]  rv_cur;
   logic [3:0]  rs_cur [4];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge aclk);
      #1;
   endtask

   function automatic logic [63:0] outs();
      return {35'd0, req_ready, mux_select, gamma_start, rsp_valid, rsp_id, rsp_data, busy};
   endfunction

   function automatic int rr_pick(input logic [3:0] v, input int last);
      for (int k = 1; k <= NR; k++) begin
         if (v[(last + k) % NR]) return (last + k) % NR;
      end
      return -1;
   endfunction

   task automatic do_reset();
      grst = 1'b1;
      req_valid = '0;
      rsp_ready = 1'b0;
      mux_out = '0;
      cyc();
      cyc();
      grst = 1'b0;
   endtask

   task automatic run_vec(input vec_t v);
      logic [3:0] s;
      s = sel_of[v.exp_id];
      req_select = sel_pack;
      req_valid  = v.rv;
      rsp_ready  = 1'b1;
      mux_out    = v.noise;
      #2;
      chk("tbl_grant", req_ready, 64'(4'b0001 << v.exp_id));
      chk("tbl_idle_busy", busy, 0);
      cyc();
      req_valid = '0;
      for (int t = 0; t < RT; t++) begin
         mux_out = ((t == v.ta) ? v.pa : 16'h0) | ((t == v.tb) ? v.pb : 16'h0);
         #2;
         chk("tbl_run_ctrl", {gamma_start, rsp_valid, busy, req_ready, mux_select},
             {(t == 0), 1'b0, 1'b1, 4'b0000, s});
         cyc();
      end
      mux_out = v.noise;
      #2;
      chk("tbl_rsp_valid", {rsp_valid, busy, mux_select}, {1'b1, 1'b1, s});
      chk("tbl_rsp_id", rsp_id, v.exp_id);
      chk("tbl_rsp_data", rsp_data, v.exp_data);
      cyc();
      mux_out = v.noise;
      #2;
      chk("tbl_post_idle", {rsp_valid, busy, gamma_start, mux_select}, {1'b0, 1'b0, 1'b0, s});
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] bp_acc;
      logic [3:0]  exp_sel;
      int          ng;
      int          last_c;
      int          cyc_n;
      int          pick;
      logic [3:0]  exp_rdy;
      bit          check_sel;
      bit          seen;

      sel_of = '{4'd5, 4'd2, 4'd3, 4'd4};
      sel_pack = {sel_of[3], sel_of[2], sel_of[1], sel_of[0]};
      //            rv       ta  pa         tb  pb         noise      id    data
      vecs[0] = '{4'b0001,  7, 16'h0008,  7, 16'h0000, 16'hFFFF, 2'd0, 16'h0008};
      vecs[1] = '{4'b0001,  0, 16'h0001, 17, 16'h8000, 16'h7FFE, 2'd0, 16'h8001};
      vecs[2] = '{4'b1111,  3, 16'h0100,  9, 16'h0100, 16'hFFFF, 2'd1, 16'h0100};
      vecs[3] = '{4'b1001, 17, 16'h0F00,  0, 16'h00F0, 16'hF00F, 2'd3, 16'h0FF0};
      vecs[4] = '{4'b1001,  5, 16'h1234, 12, 16'h4321, 16'hFFFF, 2'd0, 16'h5335};
      vecs[5] = '{4'b0110,  0, 16'h0000,  0, 16'h0000, 16'hFFFF, 2'd1, 16'h0000};

      // reset with random inputs
      #1;
      grst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         req_valid  = 4'($urandom);
         req_select = 16'($urandom);
         mux_out    = 16'($urandom);
         rsp_ready  = 1'($urandom);
         #2;
         chk("reset_outputs", outs(), 0);
         cyc();
      end
      grst = 1'b0;
      req_valid = '0;
      for (int i = 0; i < 3; i++) begin
         mux_out = 16'($urandom);
         #2;
         chk("post_reset_idle", outs(), 0);
         cyc();
      end

      // table-driven services
      do_reset();
      foreach (vecs[i]) run_vec(vecs[i]);
      cyc();

      // fairness: all requesters held valid
      do_reset();
      req_select = {4'd4, 4'd3, 4'd2, 4'd1};
      req_valid  = 4'b1111;
      rsp_ready  = 1'b1;
      mux_out    = '0;
      ng = 0; last_c = -1; cyc_n = 0; check_sel = 0; exp_sel = '0;
      while (ng < 5 && cyc_n < 150) begin
         #2;
         if (check_sel) begin
            chk("fair_select", mux_select, exp_sel);
            check_sel = 0;
         end
         if (rsp_valid) chk("fair_rsp_id", rsp_id, (ng - 1) % NR);
         if (|req_ready) begin
            chk("fair_order", req_ready, 64'(4'b0001 << (ng % NR)));
            if (ng > 0) chk("fair_spacing", cyc_n - last_c, 20);
            last_c = cyc_n;
            exp_sel = 4'(ng % NR + 1);
            check_sel = 1;
            ng++;
         end
         cyc();
         cyc_n++;
      end
      chk("fair_count", ng, 5);
      req_valid = '0;

      // backpressure on the response channel
      do_reset();
      req_select = sel_pack;
      req_valid  = 4'b0001;
      rsp_ready  = 1'b0;
      #2;
      chk("bp_grant", req_ready, 4'b0001);
      cyc();
      req_valid = 4'b0010;
      bp_acc = '0;
      for (int t = 0; t < RT; t++) begin
         mux_out = 16'($urandom);
         bp_acc |= mux_out;
         #2;
         chk("bp_run_ready", req_ready, 0);
         cyc();
      end
      for (int i = 0; i <= 10; i++) begin
         mux_out = 16'($urandom);
         rsp_ready = (i == 10);
         #2;
         chk("bp_hold", {rsp_valid, rsp_id, rsp_data, req_ready, mux_select},
             {1'b1, 2'd0, bp_acc, 4'b0000, sel_of[0]});
         cyc();
      end
      rsp_ready = 1'b0;
      #2;
      chk("bp_regrant", {req_ready, rsp_valid}, {4'b0010, 1'b0});
      cyc();
      req_valid = '0;
      cyc();

      // reset in the middle of requester 2's service
      do_reset();
      req_select = sel_pack;
      req_valid  = 4'b0100;
      rsp_ready  = 1'b1;
      #2;
      chk("midrst_grant", req_ready, 4'b0100);
      cyc();
      req_valid = '0;
      for (int t = 0; t < 8; t++) begin
         mux_out = 16'($urandom);
         cyc();
      end
      grst = 1'b1;
      #1;
      chk("midrst_outputs", outs(), 0);
      cyc();
      cyc();
      grst = 1'b0;
      req_valid = 4'b0101;
      #2;
      chk("midrst_regrant", req_ready, 4'b0001);
      cyc();
      req_valid = '0;
      seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         #2;
         if (rsp_valid) begin
            chk("midrst_rsp_id", rsp_id, 0);
            seen = 1;
         end
         cyc();
      end
      chk("midrst_rsp_seen", seen, 1);
      cyc();

      // randomized run against the reference model
      do_reset();
      m_since = 0; m_last = NR - 1; m_sel = '0; m_id = '0; m_acc = '0;
      rv_cur = '0;
      for (int i = 0; i < NR; i++) rs_cur[i] = '0;
      for (int n = 0; n < 3000; n++) begin
         for (int i = 0; i < NR; i++) begin
            if (rv_cur[i]) rv_cur[i] = ($urandom_range(0, 3) != 0);
            else           rv_cur[i] = ($urandom_range(0, 2) == 0);
            if (!rv_cur[i]) rs_cur[i] = 4'($urandom_range(0, 15));
         end
         req_valid  = rv_cur;
         req_select = {rs_cur[3], rs_cur[2], rs_cur[1], rs_cur[0]};
         mux_out    = 16'($urandom);
         rsp_ready  = 1'($urandom_range(0, 1));
         #2;
         pick = (m_since == 0) ? rr_pick(rv_cur, m_last) : -1;
         exp_rdy = (pick < 0) ? 4'b0000 : 4'(4'b0001 << pick);
         chk("rand_ctrl", {req_ready, busy, rsp_valid, gamma_start, mux_select},
             {exp_rdy, (m_since != 0), (m_since == RT + 1), (m_since == 1), m_sel});
         if (m_since == RT + 1) chk("rand_rsp", {rsp_id, rsp_data}, {m_id, m_acc});
         if (m_since == 0) begin
            if (pick >= 0) begin
               m_last  = pick;
               m_id    = 2'(pick);
               m_sel   = rs_cur[pick];
               m_acc   = '0;
               m_since = 1;
            end
         end else if (m_since <= RT) begin
            m_acc |= mux_out;
            m_since++;
         end else if (rsp_ready) begin
            m_since = 0;
         end
         cyc();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
